// File: rtl/rf_arb_pkg.sv
// ---------------------------------------------------------------------------
// rf_arb_pkg
// Shared constants, types and helpers for the register-file read arbiter.
//   NREQ_MAX : largest supported requester count
//   RF_SELW  : register index width of the shared read mux
//   RF_WIDTH : register word width
//   req_id_t : requester index wide enough for NREQ_MAX requesters
//   clog2()  : ceiling log2, usable in parameter expressions
// ---------------------------------------------------------------------------
package rf_arb_pkg;

   localparam int NREQ_MAX = 8;
   localparam int RF_SELW  = 5;
   localparam int RF_WIDTH = 32;

   typedef logic [2:0] req_id_t;

   // Returns the number of bits needed to encode n distinct values.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: grants the first asserted request found
// searching upward from ptr with wrap-around.
//   req : request vector, one bit per requester
//   ptr : index where the search starts (highest priority this cycle)
//   en  : when low, no grant is issued
//   gnt : one-hot grant (all-zero when nothing is granted)
//   idx : encoded index of the granted requester (0 when nothing granted)
// ---------------------------------------------------------------------------
module rr_arbiter
   import rf_arb_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IDW = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx
);

   always_comb begin : pick
      int  j;
      logic found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr) + k) % NREQ;
         if (en && !found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = IDW'(j);
         end
      end
   end

endmodule

// File: rtl/regfile_read_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_read_arbiter
// Shares one register read mux between NREQ requesters. A round-robin grant
// (S0) loads the mux select (S1); one cycle later the settled mux word is
// captured with the requester id into the response register (S2).
//   clk       : clock, all state updates on the rising edge
//   rst_n     : synchronous active-low reset
//   req_valid : per-requester read pending
//   req_sel   : per-requester register index, requester i at [i*SELW +: SELW]
//   req_ready : one-hot grant
//   mux_sel   : registered select driven to the external mux
//   mux_y     : combinational word returned by the external mux
//   rsp_valid : response valid
//   rsp_id    : requester the response belongs to
//   rsp_data  : captured mux word
//   rsp_ready : response consumer accepts
//
// Handshake: on both the request and the response side a transfer happens
// on a rising edge where valid and ready are both high. A requester keeps
// valid and its select stable until it sees ready; the response holds id and
// data stable while valid is high and ready is low.
// ---------------------------------------------------------------------------
module regfile_read_arbiter
   import rf_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int SELW  = RF_SELW,
   parameter int WIDTH = RF_WIDTH,
   localparam int IDW  = clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*SELW-1:0] req_sel,
   output logic [NREQ-1:0]      req_ready,
   output logic [SELW-1:0]      mux_sel,
   input  logic [WIDTH-1:0]     mux_y,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic [WIDTH-1:0]     rsp_data,
   input  logic                 rsp_ready
);

   logic [IDW-1:0]  ptr;
   logic            s1_valid;
   logic [IDW-1:0]  s1_id;

   logic            stall;
   logic            arb_en;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_idx;
   logic            accept;
   logic [SELW-1:0] gnt_sel;
   logic            s1_adv;
   logic [IDW-1:0]  ptr_next;

   // S1 cannot move only when it holds an entry and S2 is full and not
   // being drained. An empty S1 can always take a new grant.
   assign stall  = rsp_valid & ~rsp_ready & s1_valid;
   assign arb_en = rst_n & ~stall;
   assign s1_adv = s1_valid & (~rsp_valid | rsp_ready);

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req (req_valid),
      .ptr (ptr),
      .en  (arb_en),
      .gnt (gnt),
      .idx (gnt_idx)
   );

   assign req_ready = gnt;
   assign accept    = |gnt;
   assign ptr_next  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

   // One-hot grant selects the winning requester's register index.
   always_comb begin
      gnt_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            gnt_sel = gnt_sel | req_sel[i*SELW +: SELW];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr       <= '0;
         mux_sel   <= '0;
         s1_valid  <= 1'b0;
         s1_id     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         // S0 -> S1. mux_sel only moves on a grant so the mux output stays
         // quiet while the pipeline is idle.
         if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
               s1_id   <= gnt_idx;
               mux_sel <= gnt_sel;
               ptr     <= ptr_next;
            end
         end

         // S1 -> S2. mux_y has had the whole S1 cycle to settle.
         if (s1_adv) begin
            rsp_valid <= 1'b1;
            rsp_id    <= s1_id;
            rsp_data  <= mux_y;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_read_arbiter
// Directed bench: behavioural 32-word mux, table of per-cycle vectors for
// round-robin fairness, hand-written sequences for latency, wrap-around,
// backpressure and mid-flight reset, plus a response scoreboard.
// ---------------------------------------------------------------------------
module tb_regfile_read_arbiter;

   localparam int NREQ  = 4;
   localparam int SELW  = 5;
   localparam int WIDTH = 32;
   localparam int IDW   = 2;
   localparam int SBW   = IDW + WIDTH;

   // clock / reset
   logic clk;
   logic rst_n;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [NREQ-1:0]      req_valid;
   logic [NREQ*SELW-1:0] req_sel;
   logic [NREQ-1:0]      req_ready;
   logic [SELW-1:0]      mux_sel;
   logic [WIDTH-1:0]     mux_y;
   logic                 rsp_valid;
   logic [IDW-1:0]       rsp_id;
   logic [WIDTH-1:0]     rsp_data;
   logic                 rsp_ready;

   // behavioural stand-in for the shared register read mux
   logic [WIDTH-1:0] mem [32];
   always_comb mux_y = mem[mux_sel];

   regfile_read_arbiter #(.NREQ(NREQ), .SELW(SELW), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_sel   (req_sel),
      .req_ready (req_ready),
      .mux_sel   (mux_sel),
      .mux_y     (mux_y),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_ready (rsp_ready)
   );

   int n_pass  = 0;
   int n_total = 0;
   logic [SBW-1:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
   endtask

   function automatic logic [NREQ*SELW-1:0] pack(input logic [4:0] a, input logic [4:0] b,
                                                 input logic [4:0] c, input logic [4:0] d);
      return {d, c, b, a};
   endfunction

   task automatic fill_identity();
      for (int i = 0; i < 32; i++) mem[i] = 32'(i);
   endtask

   task automatic fill_tagged();
      for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
   endtask

   // Scoreboard: retire the oldest expectation on a response handshake,
   // then record a new one on a request handshake.
   task automatic monitor();
      logic [SELW-1:0] s;
      logic [IDW-1:0]  id;
      chk("gnt_legal", 64'(req_ready & ~req_valid), 64'd0);
      chk("gnt_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL sb_underflow at %0t: got id %0d data %0h expected none", $time, rsp_id, rsp_data);
            end else begin
               chk("sb_rsp", 64'({rsp_id, rsp_data}), 64'(exp_q.pop_front()));
            end
         end
         if (|(req_valid & req_ready)) begin
            s  = '0;
            id = '0;
            for (int i = 0; i < NREQ; i++) begin
               if (req_ready[i]) begin
                  s  = req_sel[i*SELW +: SELW];
                  id = IDW'(i);
               end
            end
            exp_q.push_back({id, mem[s]});
         end
      end
   endtask

   // driver: apply inputs just after the rising edge, sample at the falling edge
   task automatic step(input logic rst, input logic [NREQ-1:0] v,
                       input logic [NREQ*SELW-1:0] s, input logic r);
      @(posedge clk);
      #1;
      rst_n     = rst;
      req_valid = v;
      req_sel   = s;
      rsp_ready = r;
      @(negedge clk);
      monitor();
   endtask

   typedef struct {
      logic [NREQ-1:0]  v;
      logic             r;
      logic [NREQ-1:0]  exp_gnt;
      logic             exp_rv;
      logic [IDW-1:0]   exp_id;
      logic [WIDTH-1:0] exp_data;
   } vec_t;

   vec_t tbl [11];

   initial begin
      // fairness: all four requesters valid, sel 1..4, mux word = index
      tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 32'd0};
      tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, 32'd0};
      tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd0, 32'd1};
      tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd1, 32'd2};
      tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd2, 32'd3};
      tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd3, 32'd4};
      tbl[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd0, 32'd1};
      tbl[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd1, 32'd2};
      tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 32'd3};
      tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 32'd4};
      tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 32'd4};

      rst_n     = 1'b0;
      req_valid = '0;
      req_sel   = '0;
      rsp_ready = 1'b1;
      fill_identity();

      // reset: grant suppressed while rst_n is low even with requests present
      step(1'b0, 4'b1111, pack(5'd7, 5'd0, 5'd0, 5'd0), 1'b1);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      step(1'b0, 4'b0000, '0, 1'b1);

      // single request: requester 0 reads index 7
      step(1'b1, 4'b0000, '0, 1'b1);
      chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("idle_rsp_id", 64'(rsp_id), 64'd0);
      chk("idle_rsp_data", 64'(rsp_data), 64'd0);
      chk("idle_mux_sel", 64'(mux_sel), 64'd0);
      chk("idle_req_ready", 64'(req_ready), 64'd0);
      step(1'b1, 4'b0001, pack(5'd7, 5'd0, 5'd0, 5'd0), 1'b1);
      chk("single_grant", 64'(req_ready), 64'b0001);
      step(1'b1, 4'b0000, '0, 1'b1);
      chk("single_n1_valid", 64'(rsp_valid), 64'd0);
      chk("single_mux_sel", 64'(mux_sel), 64'd7);
      step(1'b1, 4'b0000, '0, 1'b1);
      chk("single_n2_valid", 64'(rsp_valid), 64'd1);
      chk("single_n2_id", 64'(rsp_id), 64'd0);
      chk("single_n2_data", 64'(rsp_data), 64'd7);
      step(1'b1, 4'b0000, '0, 1'b1);
      chk("single_n3_valid", 64'(rsp_valid), 64'd0);
      chk("single_mux_hold", 64'(mux_sel), 64'd7);

      // fairness table, starting from a fresh pointer
      step(1'b0, 4'b0000, '0, 1'b1);
      for (int k = 0; k < 11; k++) begin
         step(1'b1, tbl[k].v, pack(5'd1, 5'd2, 5'd3, 5'd4), tbl[k].r);
         chk($sformatf("fair%0d_gnt", k), 64'(req_ready), 64'(tbl[k].exp_gnt));
         chk($sformatf("fair%0d_rv", k), 64'(rsp_valid), 64'(tbl[k].exp_rv));
         chk($sformatf("fair%0d_id", k), 64'(rsp_id), 64'(tbl[k].exp_id));
         chk($sformatf("fair%0d_data", k), 64'(rsp_data), 64'(tbl[k].exp_data));
      end

      // wrap-around: move ptr to 3, then requesters 1 (idx 0) and 3 (idx 31)
      step(1'b1, 4'b0100, pack(5'd0, 5'd0, 5'd5, 5'd31), 1'b1);
      chk("wrap_pre_grant", 64'(req_ready), 64'b0100);
      step(1'b1, 4'b1010, pack(5'd0, 5'd0, 5'd5, 5'd31), 1'b1);
      chk("wrap_first", 64'(req_ready), 64'b1000);
      step(1'b1, 4'b1010, pack(5'd0, 5'd0, 5'd5, 5'd31), 1'b1);
      chk("wrap_second", 64'(req_ready), 64'b0010);
      chk("wrap_rsp2_data", 64'(rsp_data), 64'd5);
      step(1'b1, 4'b0000, '0, 1'b1);
      chk("wrap_rsp3_valid", 64'(rsp_valid), 64'd1);
      chk("wrap_rsp3_id", 64'(rsp_id), 64'd3);
      chk("wrap_rsp3_data", 64'(rsp_data), 64'd31);
      step(1'b1, 4'b0000, '0, 1'b1);
      chk("wrap_rsp1_id", 64'(rsp_id), 64'd1);
      chk("wrap_rsp1_data", 64'(rsp_data), 64'd0);
      step(1'b1, 4'b0000, '0, 1'b1);

      // backpressure: three back-to-back requests, then rsp_ready low 3 cycles
      fill_tagged();
      step(1'b1, 4'b0001, pack(5'd10, 5'd0, 5'd0, 5'd0), 1'b1);
      step(1'b1, 4'b0001, pack(5'd11, 5'd0, 5'd0, 5'd0), 1'b1);
      step(1'b1, 4'b0001, pack(5'd12, 5'd0, 5'd0, 5'd0), 1'b1);
      chk("bp_head_data", 64'(rsp_data), 64'hC0DE_000A);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 4'b0001, pack(5'd13, 5'd0, 5'd0, 5'd0), 1'b0);
         chk($sformatf("bp%0d_ready", k), 64'(req_ready), 64'd0);
         chk($sformatf("bp%0d_rv", k), 64'(rsp_valid), 64'd1);
         chk($sformatf("bp%0d_id", k), 64'(rsp_id), 64'd0);
         chk($sformatf("bp%0d_data", k), 64'(rsp_data), 64'hC0DE_000B);
         chk($sformatf("bp%0d_mux", k), 64'(mux_sel), 64'd12);
      end
      step(1'b1, 4'b0000, '0, 1'b1);
      chk("bp_release_data", 64'(rsp_data), 64'hC0DE_000B);
      step(1'b1, 4'b0000, '0, 1'b1);
      chk("bp_last_data", 64'(rsp_data), 64'hC0DE_000C);
      step(1'b1, 4'b0000, '0, 1'b1);
      chk("bp_drained", 64'(rsp_valid), 64'd0);
      chk("bp_sb_empty", 64'(exp_q.size()), 64'd0);

      // reset mid-flight: entries in S1 and S2, then one reset cycle
      step(1'b1, 4'b0001, pack(5'd3, 5'd0, 5'd0, 5'd0), 1'b1);
      step(1'b1, 4'b0001, pack(5'd4, 5'd0, 5'd0, 5'd0), 1'b1);
      step(1'b0, 4'b0001, pack(5'd5, 5'd0, 5'd0, 5'd0), 1'b0);
      chk("mid_rst_ready", 64'(req_ready), 64'd0);
      chk("mid_rst_inflight", 64'(rsp_valid), 64'd1);
      // ptr must be back at 0: requester 0 wins over requester 3
      step(1'b1, 4'b1001, pack(5'd9, 5'd0, 5'd0, 5'd10), 1'b1);
      chk("mid_post_rv", 64'(rsp_valid), 64'd0);
      chk("mid_post_data", 64'(rsp_data), 64'd0);
      chk("mid_post_mux", 64'(mux_sel), 64'd0);
      chk("mid_post_grant", 64'(req_ready), 64'b0001);
      step(1'b1, 4'b0000, '0, 1'b1);
      chk("mid_n1_rv", 64'(rsp_valid), 64'd0);
      step(1'b1, 4'b0000, '0, 1'b1);
      chk("mid_n2_rv", 64'(rsp_valid), 64'd1);
      chk("mid_n2_id", 64'(rsp_id), 64'd0);
      chk("mid_n2_data", 64'(rsp_data), 64'hC0DE_0009);
      step(1'b1, 4'b0000, '0, 1'b1);
      chk("mid_n3_rv", 64'(rsp_valid), 64'd0);
      chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_read_arbiter.md
# regfile_read_arbiter

Shares the single 32-way, 32-bit register read mux (`mux`: 32 words in, 5-bit select, 32-bit out) between several requesters: decode, branch unit, debug read-back and others. Each cycle a round-robin arbiter grants one pending read request and drives the mux select. The block captures the mux output and returns it, tagged with the requester ID, through a two-stage pipeline with backpressure. It sits between the requesters and the existing `mux` instance, and never modifies the mux itself.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `SELW`, 5: mux select width; the mux has 2**SELW inputs.
- `WIDTH`, 32: data word width.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `req_valid`  input  NREQ  bit i is high when requester i has a read pending.
- `req_sel`  input  NREQ*SELW  register index of requester i, in bits [i*SELW +: SELW].
- `req_ready`  output  NREQ  one-hot grant; requester i's request is accepted in a cycle where `req_valid[i]` and `req_ready[i]` are both high.
- `mux_sel`  output  SELW  registered select to the `mux` instance.
- `mux_y`  input  WIDTH  combinational output of the `mux` instance.
- `rsp_valid`  output  1  response valid.
- `rsp_id`  output  log2(NREQ)  requester index the response belongs to.
- `rsp_data`  output  WIDTH  captured mux word.
- `rsp_ready`  input  1  response consumer accepts.

## Operation
- Pipeline stages:
  - S0: arbitrate.
  - S1: `mux_sel` register plus `s1_valid` and `s1_id`; the mux settles during this stage.
  - S2: `rsp_*` registers.
- Stall rule:
  - `stall = rsp_valid & ~rsp_ready & s1_valid`.
  - Under stall, S1 and S2 hold their contents and `req_ready` is all-zero.
  - If S2 is full but S1 is empty, S0 may still grant into S1.
- S1 → S2 transfer: when S1 is valid and S2 is empty or being accepted, S2 loads `mux_y`, `s1_id` and valid.
- S2 clear: when `rsp_ready` is high and S1 is not advancing, `rsp_valid` clears.
- Arbitration is round-robin with pointer `ptr`:
  - The grant goes to the first i with `req_valid[i]`, searching from `ptr` upward with wrap-around.
  - After an accepted grant to i, `ptr` becomes (i+1) mod NREQ.
  - With no grant, `ptr` holds.
- `req_ready` is combinational from `req_valid`, `ptr` and the stall condition. At most one bit is high, and a bit is never high without the matching `req_valid`.
- `mux_sel` holds its last value when S1 empties; it changes only on a grant.
- Reset values: `mux_sel`=0, `ptr`=0, `s1_valid`=0, `s1_id`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `req_ready`=0 while `rst_n` is low.
- Reset mid-operation: in-flight S1/S2 entries are discarded without a response, and no partial response is ever emitted.

## Timing
- Request accepted in cycle N → `mux_sel` updated at the N edge → `rsp_valid` high in cycle N+2 with `rsp_data` = word at index `req_sel`. Latency is 2 cycles.
- Throughput: one request per cycle when `rsp_ready` is held high.
- Simultaneous requests: the grant order follows `ptr`; a requester holding `req_valid` high is served within NREQ grants.
- When `rsp_ready` is low with S1 and S2 full, all state is frozen. The cycle `rsp_ready` returns, S2 retires and S1 advances.
- A requester that changes `req_sel` while not granted is legal; the select is sampled only on acceptance.

## Structure
- Shared package `rf_arb_pkg`:
  - constants `NREQ_MAX=8`, `RF_SELW=5`, `RF_WIDTH=32`;
  - typedef `req_id_t` (3 bits);
  - function `clog2`.
- One sub-module, `rr_arbiter`:
  - parameter NREQ;
  - inputs: req vector, pointer, enable;
  - outputs: one-hot grant, encoded index.
- The top contains only the pipeline registers and pointer update.
- The top instantiates the existing `mux` only in the bench, not in the block.

## Test plan
- Reset, single request: reset, then requester 0 reads index 7 with the mux loaded arr[i]=i → `rsp_valid` in cycle N+2, `rsp_id`=0, `rsp_data`=7. Before the request, all outputs are 0.
- All-request fairness: all 4 requesters valid continuously with sel=1,2,3,4 → grants 0,1,2,3,0,…; responses 1,2,3,4 repeating with one response per cycle.
- Backpressure: back-to-back requests, then `rsp_ready`=0 for 3 cycles → `rsp_data` and `rsp_id` are stable and `req_ready`=0. No response is lost or duplicated after release.
- Wrap-around: `ptr`=3 with requesters 1 and 3 valid → requester 3 is granted first, then 1; indices 31 and 0 return 31 and 0.
- Reset mid-flight: requests in S1 and S2, then `rst_n` low for 1 cycle → `rsp_valid`=0 from the next edge, `ptr`=0, and the next request is served normally.
